// File: rtl/random_pkg.sv
// rtl/random_pkg.sv - shared types and defaults for the random sample reader
package random_pkg;

  localparam int NBITS_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_COLLECT,
    ST_STOP,
    ST_DRAIN
  } state_t;

  // One queued sample at the default word width: engine word plus end-of-request tag.
  typedef struct packed {
    logic [NBITS_DEFAULT-1:0] data;
    logic                     last;
  } entry_t;

endpackage

// File: rtl/sample_queue.sv
// rtl/sample_queue.sv - small power-of-two FIFO holding tagged samples
module sample_queue #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  // A full queue refuses the push even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset; the consumer only looks at it when the queue is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/random_sample_reader.sv
// rtl/random_sample_reader.sv - collects N engine words and streams them downstream
module random_sample_reader
  import random_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT,
  parameter int DEPTH = 4,
  parameter int CBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [CBITS-1:0] req_count,
  output logic             eng_start,
  output logic             eng_stop,
  input  logic             eng_active,
  input  logic [NBITS-1:0] eng_out,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  state_t                  state_q;
  state_t                  state_d;
  logic [CBITS-1:0]        rem_q;
  logic [CBITS-1:0]        rem_d;
  logic                    push;
  logic                    push_last;
  logic                    q_full;
  logic                    q_empty;
  logic [$clog2(DEPTH):0]  q_count;
  logic [NBITS:0]          head_entry;

  sample_queue #(
    .WIDTH (NBITS + 1),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({eng_out, push_last}),
    .pop       (out_val && out_rdy),
    .head      (head_entry),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // State and remaining-sample counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next state plus Moore control outputs; the push strobe follows the engine while collecting.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    req_rdy   = 1'b0;
    eng_start = 1'b0;
    eng_stop  = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_rdy = 1'b1;
        // A zero-count request is accepted but does nothing.
        if (req_val && (req_count != '0)) begin
          rem_d   = req_count;
          state_d = ST_START;
        end
      end
      ST_START: begin
        eng_start = 1'b1;
        state_d   = ST_COLLECT;
      end
      ST_COLLECT: begin
        // Words arriving while the queue is full are dropped; the engine keeps running.
        if (eng_active && !q_full) begin
          push  = 1'b1;
          rem_d = rem_q - CBITS'(1);
          if (rem_q == CBITS'(1)) begin
            push_last = 1'b1;
            state_d   = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        eng_stop = 1'b1;
        state_d  = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (q_count == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Head fields are masked so stale storage never leaks out of an empty queue.
  assign out_val  = !q_empty;
  assign out_data = out_val ? head_entry[NBITS:1] : '0;
  assign out_last = out_val && head_entry[0];
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_random_sample_reader.sv
// tb/tb_random_sample_reader.sv - self-checking bench for random_sample_reader
module tb_random_sample_reader;
  import random_pkg::*;

  localparam int NB = 8;
  localparam int DP = 4;
  localparam int CB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_val = 1'b0;
  logic          req_rdy;
  logic [CB-1:0] req_count = '0;
  logic          eng_start;
  logic          eng_stop;
  logic          eng_active;
  logic [NB-1:0] eng_word;
  logic          out_val;
  logic          out_rdy = 1'b0;
  logic [NB-1:0] out_data;
  logic          out_last;
  logic          busy;

  int tests = 0;
  int fails = 0;

  random_sample_reader #(.NBITS(NB), .DEPTH(DP), .CBITS(CB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_count  (req_count),
    .eng_start  (eng_start),
    .eng_stop   (eng_stop),
    .eng_active (eng_active),
    .eng_out    (eng_word),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Engine model: counts 1,2,3... advancing every cycle while active.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_active <= 1'b0;
      eng_word   <= 8'h01;
    end else begin
      if (eng_start)     eng_active <= 1'b1;
      else if (eng_stop) eng_active <= 1'b0;
      if (eng_active)    eng_word <= eng_word + 8'h01;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: sample queue as a SV queue, request phases from the timing rules.
  entry_t mq[$];
  entry_t got[$];
  int     m_rem = 0;
  int     m_post = 0;
  bit     m_idle = 1'b1;
  bit     m_start = 1'b0;
  int     n_start = 0;
  int     n_stop = 0;

  always @(posedge clk or negedge rst) begin
    int sz;
    bit acc;
    bit pop;
    bit psh;
    if (!rst) begin
      mq.delete();
      m_rem   = 0;
      m_post  = 0;
      m_idle  = 1'b1;
      m_start = 1'b0;
    end else begin
      if (out_val && out_rdy) got.push_back('{data: out_data, last: out_last});
      if (eng_start) n_start++;
      if (eng_stop)  n_stop++;
      sz  = mq.size();
      acc = m_idle && req_val && (req_count != 0);
      pop = (sz > 0) && out_rdy;
      psh = (m_rem > 0) && eng_active && (sz < DP);
      if (m_post == 2 && sz == 0) begin
        m_post = 0;
        m_idle = 1'b1;
      end else if (m_post == 1) begin
        m_post = 2;
      end
      m_start = acc;
      if (acc) begin
        m_idle = 1'b0;
        m_rem  = int'(req_count);
      end
      if (pop) void'(mq.pop_front());
      if (psh) begin
        mq.push_back('{data: eng_word, last: (m_rem == 1)});
        if (m_rem == 1) m_post = 1;
        m_rem--;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      check("out_val",   out_val,   mq.size() > 0);
      check("out_data",  out_data,  (mq.size() > 0) ? mq[0].data : 8'h00);
      check("out_last",  out_last,  (mq.size() > 0) ? mq[0].last : 1'b0);
      check("req_rdy",   req_rdy,   m_idle);
      check("busy",      busy,      !m_idle);
      check("eng_start", eng_start, m_start);
      check("eng_stop",  eng_stop,  m_post == 1);
    end
  end

  task automatic request(input int c);
    bit ok;
    logic [31:0] cv;
    ok = 1'b0;
    cv = c;
    @(negedge clk);
    req_val   = 1'b1;
    req_count = cv[CB-1:0];
    for (int k = 0; k < 100; k++) begin
      if (req_rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    req_val   = 1'b0;
    req_count = '0;
    check("req_accepted", ok, 1);
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (rnd) out_rdy = 1'($urandom_range(0, 1));
      if (req_rdy && !busy) begin
        done = 1'b1;
        break;
      end
    end
    check("idle_reached", done, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic clear_log();
    got.delete();
    n_start = 0;
    n_stop  = 0;
  endtask

  initial begin
    int c;
    int nlast;
    bit ok;

    // Reset values while held in reset.
    repeat (2) @(negedge clk);
    check("rst_req_rdy",   req_rdy,   1);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_stop",  eng_stop,  0);
    check("rst_out_val",   out_val,   0);
    check("rst_out_last",  out_last,  0);
    check("rst_busy",      busy,      0);
    check("rst_out_data",  out_data,  0);
    #2 rst = 1'b1;

    // Basic request of 3 with the sink always ready.
    clear_log();
    out_rdy = 1'b1;
    request(3);
    wait_idle(50, 1'b0);
    check("basic_n", got.size(), 3);
    if (got.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("basic_data", got[i].data, i + 1);
        check("basic_last", got[i].last, i == 2);
      end
    end
    check("basic_starts", n_start, 1);
    check("basic_stops",  n_stop,  1);

    // Zero-count request is a no-op.
    clear_log();
    request(0);
    repeat (4) begin
      @(negedge clk);
      check("zero_busy", busy, 0);
      check("zero_rdy",  req_rdy, 1);
    end
    check("zero_starts", n_start, 0);
    check("zero_out",    got.size(), 0);

    // Backpressure: queue fills with 01..04, later words are dropped.
    do_reset();
    clear_log();
    out_rdy = 1'b0;
    request(6);
    repeat (10) @(negedge clk);
    check("bp_head",    out_data, 8'h01);
    check("bp_no_stop", n_stop, 0);
    check("bp_no_pop",  got.size(), 0);
    out_rdy = 1'b1;
    wait_idle(60, 1'b0);
    check("bp_n", got.size(), 6);
    if (got.size() == 6) begin
      for (int i = 0; i < 4; i++) check("bp_data", got[i].data, i + 1);
      check("bp_skip5", got[4].data > 8'h04, 1);
      check("bp_skip6", got[5].data > got[4].data, 1);
      for (int i = 0; i < 6; i++) check("bp_last", got[i].last, i == 5);
    end

    // Asynchronous reset in the middle of collecting.
    do_reset();
    clear_log();
    out_rdy = 1'b0;
    request(8);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mq.size() == 2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("mid_two_queued", ok, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_out_val",  out_val,  0);
    check("mid_busy",     busy,     0);
    check("mid_req_rdy",  req_rdy,  1);
    check("mid_out_data", out_data, 0);
    check("mid_out_last", out_last, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    clear_log();
    out_rdy = 1'b1;
    request(1);
    wait_idle(40, 1'b0);
    check("mid_n", got.size(), 1);
    if (got.size() == 1) check("mid_last", got[0].last, 1);

    // Back-to-back: second request offered while the first drains.
    clear_log();
    out_rdy = 1'b0;
    request(2);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (n_stop == 1) begin
        ok = 1'b1;
        break;
      end
    end
    check("b2b_first_stop", ok, 1);
    check("b2b_rdy_in_drain",  req_rdy, 0);
    check("b2b_busy_in_drain", busy, 1);
    fork
      request(2);
      begin
        repeat (3) @(negedge clk);
        out_rdy = 1'b1;
      end
    join
    wait_idle(60, 1'b0);
    check("b2b_starts", n_start, 2);
    check("b2b_stops",  n_stop,  2);
    check("b2b_n",      got.size(), 4);
    if (got.size() == 4) begin
      for (int i = 0; i < 4; i++) check("b2b_last", got[i].last, (i % 2) == 1);
    end

    // Randomized counts with random sink backpressure.
    for (int it = 0; it < 8; it++) begin
      c = $urandom_range(1, 9);
      clear_log();
      out_rdy = 1'($urandom_range(0, 1));
      request(c);
      wait_idle(300, 1'b1);
      out_rdy = 1'b0;
      check("rnd_n",      got.size(), c);
      check("rnd_starts", n_start, 1);
      check("rnd_stops",  n_stop,  1);
      if (got.size() == c) begin
        nlast = 0;
        foreach (got[i]) nlast += int'(got[i].last);
        check("rnd_one_last", nlast, 1);
        check("rnd_final_last", got[c-1].last, 1);
        for (int i = 1; i < c; i++) check("rnd_increasing", got[i].data > got[i-1].data, 1);
      end
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
